// File: rtl/qsys_pkg.sv
// qsys_pkg: shared state type, counter sizing and data pattern for the qsys traffic master
package qsys_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int MAX_WIDTH = 64;
    localparam int DEF_NUM_TRANS = 16;
    localparam int DEF_MAX_OUTSTANDING = 4;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int DEF_SEQ_W = cnt_width(DEF_NUM_TRANS);
    localparam int DEF_OUT_W = cnt_width(DEF_MAX_OUTSTANDING);

    function automatic logic [MAX_WIDTH-1:0] pat(input logic [7:0] src, input logic [7:0] snk,
                                                 input logic [MAX_WIDTH-1:0] i, input int width);
        return (MAX_WIDTH'(src) << (width - 8)) | (MAX_WIDTH'(snk) << (width - 16)) | i;
    endfunction

endpackage

// File: rtl/qsys_resp_checker.sv
// qsys_resp_checker: counts read responses, compares them to the expected pattern, holds sticky error
import qsys_pkg::*;

module qsys_resp_checker #(
    parameter int         WIDTH     = 32,
    parameter logic [7:0] SRC_ID    = 8'd0,
    parameter logic [7:0] SNK_ID    = 8'd1,
    parameter int         NUM_TRANS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             readdatavalid,
    input  logic [WIDTH-1:0] readdata,
    input  logic             outstanding_zero,
    output logic             rcount_done,
    output logic             error
);
    localparam int CW = cnt_width(NUM_TRANS);

    logic [CW-1:0] rcount;
    logic          rv_ok;

    assign rv_ok = readdatavalid && !outstanding_zero;
    // Includes the response arriving this cycle so done can register one cycle after the last one.
    assign rcount_done = rcount == CW'(NUM_TRANS) || (rv_ok && rcount == CW'(NUM_TRANS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            rcount <= '0;
            error  <= 1'b0;
        end else if (readdatavalid) begin
            if (rv_ok)
                rcount <= rcount + 1'b1;
            if (!rv_ok || readdata != WIDTH'(pat(SRC_ID, SNK_ID, MAX_WIDTH'(rcount), WIDTH)))
                error <= 1'b1;
        end
    end

endmodule

// File: rtl/qsys_master.sv
// qsys_master: Avalon-MM traffic generator writing a pattern burst then reading it back with bounded pipelining
import qsys_pkg::*;

module qsys_master #(
    parameter int         WIDTH           = 32,
    parameter int         ADDR_WIDTH      = 30,
    parameter logic [7:0] SRC_ID          = 8'd0,
    parameter logic [7:0] SNK_ID          = 8'd1,
    parameter int         NUM_TRANS       = 16,
    parameter int         MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  done,
    output logic                  error,
    output logic [WIDTH-1:0]      writedata,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  write,
    output logic                  read,
    input  logic                  waitrequest,
    input  logic [WIDTH-1:0]      readdata,
    input  logic                  readdatavalid
);
    localparam int SW = cnt_width(NUM_TRANS);
    localparam int OW = cnt_width(MAX_OUTSTANDING);

    state_t        state;
    logic [SW-1:0] seq, seq_inc;
    logic [OW-1:0] outstanding, out_nxt;
    logic          acc, rd_acc, rv_in, rv_ok, last, rcount_done;

    function automatic logic [WIDTH-1:0] pw(input logic [SW-1:0] i);
        return WIDTH'(pat(SRC_ID, SNK_ID, MAX_WIDTH'(i), WIDTH));
    endfunction

    assign rv_in   = readdatavalid && state != IDLE;
    assign rv_ok   = rv_in && outstanding != '0;
    assign acc     = (write || read) && !waitrequest;
    assign rd_acc  = read && !waitrequest;
    assign seq_inc = seq + 1'b1;
    assign last    = seq == SW'(NUM_TRANS - 1);
    assign out_nxt = outstanding + OW'(rd_acc) - OW'(rv_ok);

    qsys_resp_checker #(
        .WIDTH     (WIDTH),
        .SRC_ID    (SRC_ID),
        .SNK_ID    (SNK_ID),
        .NUM_TRANS (NUM_TRANS)
    ) u_chk (
        .clk              (clk),
        .rst              (rst),
        .readdatavalid    (rv_in),
        .readdata         (readdata),
        .outstanding_zero (outstanding == '0),
        .rcount_done      (rcount_done),
        .error            (error)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            seq         <= '0;
            outstanding <= '0;
            write       <= 1'b0;
            read        <= 1'b0;
            address     <= '0;
            writedata   <= '0;
            done        <= 1'b0;
        end else begin
            if (state != IDLE)
                outstanding <= out_nxt;
            case (state)
                IDLE: begin
                    state     <= WRITE;
                    write     <= 1'b1;
                    writedata <= pw('0);
                end
                WRITE: if (acc) begin
                    if (last) begin
                        state     <= READ;
                        seq       <= '0;
                        write     <= 1'b0;
                        read      <= 1'b1;
                        address   <= '0;
                        writedata <= '0;
                    end else begin
                        seq       <= seq_inc;
                        address   <= ADDR_WIDTH'(seq_inc);
                        writedata <= pw(seq_inc);
                    end
                end
                READ: begin
                    if (rd_acc) begin
                        seq     <= seq_inc;
                        address <= ADDR_WIDTH'(seq_inc);
                    end
                    // read is a register, so it is sized from next cycle's outstanding count.
                    if (rd_acc && last) begin
                        state <= DRAIN;
                        read  <= 1'b0;
                    end else
                        read <= out_nxt < OW'(MAX_OUTSTANDING);
                end
                DRAIN: if (rcount_done) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qsys_master.sv
// tb_qsys_master: randomized memory slave with a transaction-level scoreboard for qsys_master
module tb_qsys_master;
    localparam int N    = 16;
    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        waitrequest = 1'b0;
    logic        readdatavalid = 1'b0;
    logic [31:0] readdata = '0;
    logic        done, error, write, read;
    logic [31:0] writedata;
    logic [29:0] address;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    qsys_master #(
        .NUM_TRANS       (N),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .done          (done),
        .error         (error),
        .writedata     (writedata),
        .address       (address),
        .write         (write),
        .read          (read),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    function automatic logic [31:0] tpat(input int i);
        return 32'h0001_0000 + 32'(i);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run_test(input string name, input int lat, input int stall_at, input int bad_at,
                            input bit spur, input bit mid_rst, input int wait_pct);
        int wr = 0, rd = 0, rsp = 0, outs = 0, stalls = 0, tail = 0;
        int due[$];
        bit exp_err = 0, spur_done = 0, rst_done = 0, late = 0;
        @(negedge clk);
        rst = 1'b1;
        waitrequest = 1'b0;
        readdatavalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; tail < 4; cyc++) begin
            if (cyc > 3000) begin
                check({name, " timeout"}, 32'(rsp), 32'(N));
                break;
            end
            check({name, " write"}, 32'(write), 32'(cyc >= 1 && wr < N));
            check({name, " read"}, 32'(read), 32'(wr == N && rd < N && outs < MAXO));
            check({name, " both"}, 32'(write && read), 32'(0));
            if (write) begin
                check({name, " waddr"}, 32'(address), 32'(wr));
                check({name, " wdata"}, writedata, tpat(wr));
            end
            if (read)
                check({name, " raddr"}, 32'(address), 32'(rd));
            if (cyc == 0) begin
                check({name, " rst addr"}, 32'(address), 32'(0));
                check({name, " rst wdata"}, writedata, 32'(0));
            end
            check({name, " done"}, 32'(done), 32'(rsp == N));
            check({name, " error"}, 32'(error), 32'(exp_err));
            waitrequest = 1'b0;
            readdatavalid = 1'b0;
            readdata = $urandom;
            if (mid_rst && !rst_done && outs == 2) begin
                rst = 1'b1;
                readdatavalid = 1'b1;
                rst_done = 1;
                @(negedge clk);
                rst = 1'b0;
                late = 1;
                wr = 0; rd = 0; rsp = 0; outs = 0; exp_err = 0;
                due.delete();
                cyc = -1;
                continue;
            end
            if (write && stall_at >= 0 && address == 30'(stall_at) && stalls < 3) begin
                waitrequest = 1'b1;
                stalls++;
            end else
                waitrequest = $urandom_range(99) < wait_pct;
            if (late && cyc == 0) begin
                readdatavalid = 1'b1;
                late = 0;
            end else if (due.size() > 0 && due[0] <= cyc) begin
                void'(due.pop_front());
                readdatavalid = 1'b1;
                readdata = rsp == bad_at ? 32'hDEAD_BEEF : tpat(rsp);
                if (rsp == bad_at)
                    exp_err = 1;
                rsp++;
                outs--;
            end else if (spur && !spur_done && wr == 8) begin
                readdatavalid = 1'b1;
                readdata = tpat(0);
                exp_err = 1;
                spur_done = 1;
            end
            if (write && !waitrequest)
                wr++;
            if (read && !waitrequest) begin
                rd++;
                outs++;
                due.push_back(cyc + lat);
            end
            if (rsp == N)
                tail++;
            @(negedge clk);
        end
    endtask

    initial begin
        run_test("echo", 1, -1, -1, 0, 0, 0);
        run_test("wstall", 1, 5, -1, 0, 0, 0);
        run_test("cap", 10, -1, -1, 0, 0, 0);
        run_test("corrupt", 2, -1, 7, 0, 0, 0);
        run_test("spur", 1, -1, -1, 1, 0, 0);
        run_test("midrst", 4, -1, -1, 0, 1, 0);
        for (int k = 0; k < 4; k++)
            run_test("rand", $urandom_range(8, 1), -1, $urandom_range(20, 0) - 4, 0, 0, 30);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qsys_master.md
# qsys_master

Avalon-MM (Qsys) master traffic generator for NoC performance evaluation; the initiator counterpart of `qsys_slave`. It issues a fixed burst of writes followed by pipelined reads to a memory-like slave across the NoC, and checks every returned read word against the pattern written. It raises `done` when all responses are back and a sticky `error` on any mismatch or protocol violation. The block sits on the master side of a Qsys-to-NoC translator.

## Interface
- `WIDTH`, 32: data width; must be ≥ 24.
- `ADDR_WIDTH`, 30: address width; must be ≥ `$clog2(NUM_TRANS)`.
- `SRC_ID`, 8'd0: 8-bit id of this master, embedded in data.
- `SNK_ID`, 8'd1: 8-bit id of the target slave, embedded in data.
- `NUM_TRANS`, 16: writes issued, then the same number of reads; range 1..2^(WIDTH-16).
- `MAX_OUTSTANDING`, 4: maximum number of reads accepted but not yet answered; must be ≥ 1.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `done` out 1: high when the test has completed; stays high until `rst`.
- `error` out 1: sticky error flag.
- `writedata` out WIDTH: write data.
- `address` out ADDR_WIDTH: word address.
- `write` out 1: write request.
- `read` out 1: read request.
- `waitrequest` in 1: slave stall.
- `readdata` in WIDTH: read response data.
- `readdatavalid` in 1: read response valid.

## Operation
- **Pattern.** `pat(i) = {SRC_ID, SNK_ID, i}`, where `i` is zero-extended to WIDTH-16 bits. For transaction `i`, the address is `i` zero-extended to ADDR_WIDTH.
- **Command acceptance.** A command is accepted on a cycle where (`write` | `read`) && !`waitrequest`. While `waitrequest` is high, `address`, `writedata`, `write` and `read` hold steady. `write` and `read` are never high together.
- **IDLE.** Entered on `rst`. Leaves for WRITE on the next cycle. `readdatavalid` is ignored in IDLE.
- **WRITE.** `write`=1, `address`=`seq`, `writedata`=`pat(seq)`.
  - Each acceptance increments `seq`.
  - Acceptance with `seq`==NUM_TRANS-1 goes to READ and clears `seq` to 0.
- **READ.**
  - `read`=1 iff `outstanding` < MAX_OUTSTANDING. `address`=`seq`.
  - Each acceptance increments `seq` and `outstanding`.
  - The last acceptance goes to DRAIN.
- **DRAIN.** `read`=0. Goes to DONE when `rcount`==NUM_TRANS.
- **DONE.** `done`=1. No further commands are issued. Only `rst` leaves this state.
- **Response checking** (READ, DRAIN and DONE):
  - Each `readdatavalid` decrements `outstanding` and increments `rcount`.
  - `readdata` is compared to `pat(rcount)`, relying on in-order Avalon responses. A mismatch sets `error`.
- **Simultaneous events.** A read acceptance and `readdatavalid` in the same cycle leave `outstanding` unchanged.
- **Protocol violation.** `readdatavalid` with `outstanding`==0, in any state other than IDLE, sets `error` and does not change the counters.
- **Widths.**
  - `seq` and `rcount`: `$clog2(NUM_TRANS+1)` bits.
  - `outstanding`: `$clog2(MAX_OUTSTANDING+1)` bits.
  - None of these counters can wrap, given the guards above.

## Timing
- **Reset values.** All outputs are 0: `done`=0, `error`=0, `write`=0, `read`=0, `address`=0, `writedata`=0. All counters are 0. State is IDLE.
- **Registered outputs.** All outputs are driven from registers only; there is no combinational path from `waitrequest` or `readdatavalid` to any output.
- **Start-up.** `rst` low at cycle 0 puts the block in IDLE. `write` first rises at cycle 1.
- **Throughput with no stalls.** One write per cycle, so the last write is accepted at cycle NUM_TRANS. `read` first rises the following cycle.
- **Read issue after a stall.** When `outstanding` == MAX_OUTSTANDING, `read` drops the cycle after the acceptance that filled it. `read` re-rises the cycle after the `readdatavalid` that frees a slot.
- **Completion.** `done` rises exactly one cycle after the NUM_TRANS-th `readdatavalid`. `error` is set the cycle after the offending response.
- **Mid-test reset.** `rst` asserted during any state returns the block to IDLE with all outputs and counters 0 on the next edge. In-flight responses are dropped in IDLE.

## Structure
- Package `qsys_pkg`:
  - `state_t` enum {IDLE, WRITE, READ, DRAIN, DONE}.
  - Function `pat(src, snk, i, width)`.
  - Localparams for the counter widths.
- Sub-module `qsys_resp_checker`:
  - Owns `rcount`, the expected-pattern comparison, and the sticky `error` flag.
  - Takes `readdatavalid`, `readdata`, and an `outstanding_zero` flag.
  - Outputs `rcount_done` and `error`.
- The top level holds the FSM, `seq`, the `outstanding` counter, and the command outputs.

## Test plan
- **Zero-latency echo memory.** No `waitrequest`, NUM_TRANS=16, read latency 1. Expect: 16 writes with `writedata`=0x0001_0000..0x0001_000F at cycles 1–16; reads follow; `done`=1 one cycle after the 16th response; `error`=0.
- **Write backpressure.** `waitrequest`=1 for 3 cycles during write 5. Expect: `address`=5 and `writedata`=0x0001_0005 held stable throughout the stall; exactly 16 writes accepted.
- **Outstanding cap.** Read latency 10, MAX_OUTSTANDING=4. Expect: `outstanding` never exceeds 4; `read` is low while the count is 4; `done` still asserts; `error`=0.
- **Data corruption.** Slave returns 0xDEAD_BEEF for read 7. Expect: `error`=1 from the cycle after that response; `done` still asserts after 16 responses.
- **Spurious response.** `readdatavalid` pulses during WRITE. Expect: `error`=1; `rcount` unchanged.
- **Mid-test reset.** `rst` pulsed in READ with 2 reads outstanding. Expect: all outputs 0 next cycle; late responses ignored in IDLE; test restarts at cycle 1 with `error`=0.
